// File: rtl/alu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_pkg                                                        |
// | Purpose  : Shared constants, state encoding and carry-in selection for   |
// |            the alu_seq operand/instruction sequencer.                    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package alu_pkg;

  localparam int WIDTH = 4;  // datapath width, equals the ALU width
  localparam int NREG  = 4;  // register-file entries
  localparam int IDX_W = 2;  // register index width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  // Carry-in source selection; code 3 is reserved and behaves like CM_NONE.
  localparam logic [1:0] CM_NONE  = 2'd0;
  localparam logic [1:0] CM_ONE   = 2'd1;
  localparam logic [1:0] CM_CHAIN = 2'd2;

  // The ALU carry input is active-low: CN=0 adds one.
  function automatic logic carry_in_n(input logic [1:0] cmode, input logic cflag);
    logic cn;
    case (cmode)
      CM_ONE:   cn = 1'b0;
      CM_CHAIN: cn = ~cflag;
      default:  cn = 1'b1;
    endcase
    return cn;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_regfile                                                    |
// | Purpose  : NREG x WIDTH register file, one synchronous write port, two   |
// |            combinational operand read ports and one debug read port.     |
// | Ports    : clk, rst_n (async active-low clear)                           |
// |            we, waddr, wdata          - write port                        |
// |            raddr_a/rdata_a, raddr_b/rdata_b - operand reads              |
// |            raddr_d/rdata_d           - debug read                        |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module alu_regfile
  import alu_pkg::*;
#(
  parameter int WIDTH_P = alu_pkg::WIDTH,
  parameter int NREG_P  = alu_pkg::NREG
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [IDX_W-1:0]   waddr,
  input  logic [WIDTH_P-1:0] wdata,
  input  logic [IDX_W-1:0]   raddr_a,
  input  logic [IDX_W-1:0]   raddr_b,
  input  logic [IDX_W-1:0]   raddr_d,
  output logic [WIDTH_P-1:0] rdata_a,
  output logic [WIDTH_P-1:0] rdata_b,
  output logic [WIDTH_P-1:0] rdata_d
);

  logic [WIDTH_P-1:0] regs [NREG_P];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG_P; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];
  assign rdata_d = regs[raddr_d];

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_seq                                                        |
// | Purpose  : Operand/instruction sequencer for a 74181-style ALU. Accepts  |
// |            one instruction per valid/ready handshake, drives registered  |
// |            operands to the ALU, writes results back and keeps carry and  |
// |            zero flags for chained multi-word arithmetic.                 |
// | Ports    : clk, rst_n                  - clock, async active-low reset   |
// |            ins_*                       - instruction handshake/fields    |
// |            alu_a/b/s/m/cn (out), alu_f/co (in) - ALU connection          |
// |            res_valid/data/co/zero      - result and flags                |
// |            rd_sel/rd_data              - debug register read             |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module alu_seq #(
  parameter int WIDTH = alu_pkg::WIDTH,
  parameter int NREG  = alu_pkg::NREG
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ins_valid,
  output logic             ins_ready,
  input  logic             ins_ld,
  input  logic [WIDTH-1:0] ins_imm,
  input  logic [3:0]       ins_op,
  input  logic             ins_m,
  input  logic [1:0]       ins_cmode,
  input  logic [1:0]       ins_ra,
  input  logic [1:0]       ins_rb,
  input  logic [1:0]       ins_rd,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_s,
  output logic             alu_m,
  output logic             alu_cn,
  input  logic [WIDTH-1:0] alu_f,
  input  logic             alu_co,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             res_co,
  output logic             res_zero,
  input  logic [1:0]       rd_sel,
  output logic [WIDTH-1:0] rd_data
);

  import alu_pkg::*;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       rd_q;
  logic             cflag;
  logic             accept;
  logic             rf_we;
  logic [1:0]       rf_waddr;
  logic [WIDTH-1:0] rf_wdata;
  logic [WIDTH-1:0] ra_data;
  logic [WIDTH-1:0] rb_data;

  assign ins_ready = (state == IDLE);
  assign accept    = ins_ready && ins_valid;
  assign res_valid = (state == WB);
  assign res_co    = cflag;
  assign res_zero  = (res_data == '0);

  // Immediates write straight from the instruction at the accepting edge;
  // ALU results write at the edge closing EXEC using the latched rd.
  assign rf_we    = (accept && ins_ld) || (state == EXEC);
  assign rf_waddr = (state == EXEC) ? rd_q : ins_rd;
  assign rf_wdata = (state == EXEC) ? alu_f : ins_imm;

  alu_regfile #(
    .WIDTH_P (WIDTH),
    .NREG_P  (NREG)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .raddr_a (ins_ra),
    .raddr_b (ins_rb),
    .raddr_d (rd_sel),
    .rdata_a (ra_data),
    .rdata_b (rb_data),
    .rdata_d (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ins_valid) state_nxt = ins_ld ? WB : EXEC;
      EXEC:    state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_s    <= '0;
      alu_m    <= 1'b1;
      alu_cn   <= 1'b1;
      rd_q     <= '0;
      res_data <= '0;
      cflag    <= 1'b0;
    end else begin
      if (accept && !ins_ld) begin
        // Operands are captured here, so a later write to ra/rb cannot disturb them.
        alu_a  <= ra_data;
        alu_b  <= rb_data;
        alu_s  <= ins_op;
        alu_m  <= ins_m;
        alu_cn <= carry_in_n(ins_cmode, cflag);
        rd_q   <= ins_rd;
      end
      if (accept && ins_ld) begin
        res_data <= ins_imm;
      end
      if (state == EXEC) begin
        res_data <= alu_f;
        // Logic-mode carry out is meaningless, so only arithmetic updates the flag.
        if (!alu_m) begin
          cflag <= alu_co;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_alu_seq                                                     |
// | Purpose  : Self-checking bench for alu_seq with a behavioural 74181      |
// |            stand-in, scoreboard queue and reference register model.      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_alu_seq;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ins_valid = 1'b0;
  logic         ins_ready;
  logic         ins_ld = 1'b0;
  logic [W-1:0] ins_imm = '0;
  logic [3:0]   ins_op = '0;
  logic         ins_m = 1'b0;
  logic [1:0]   ins_cmode = '0;
  logic [1:0]   ins_ra = '0;
  logic [1:0]   ins_rb = '0;
  logic [1:0]   ins_rd = '0;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [3:0]   alu_s;
  logic         alu_m;
  logic         alu_cn;
  logic [W-1:0] alu_f;
  logic         alu_co;
  logic         res_valid;
  logic [W-1:0] res_data;
  logic         res_co;
  logic         res_zero;
  logic [1:0]   rd_sel = '0;
  logic [W-1:0] rd_data;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [W-1:0] val;
    logic         co;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] m_regs [4];
  logic         m_cflag;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_seq #(.WIDTH(W), .NREG(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_ld(ins_ld), .ins_imm(ins_imm),
    .ins_op(ins_op), .ins_m(ins_m), .ins_cmode(ins_cmode),
    .ins_ra(ins_ra), .ins_rb(ins_rb), .ins_rd(ins_rd),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_cn(alu_cn),
    .alu_f(alu_f), .alu_co(alu_co),
    .res_valid(res_valid), .res_data(res_data), .res_co(res_co), .res_zero(res_zero),
    .rd_sel(rd_sel), .rd_data(rd_data)
  );

  // 74181 behaviour with active-high data; cin=1 adds one. Returns {carry, F}.
  function automatic logic [W:0] alu181(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [3:0] s, input logic m, input logic cin);
    logic [W-1:0] p;
    logic [W-1:0] q;
    logic [W-1:0] f;
    p = '0; q = '0; f = '0;
    if (m) begin
      case (s)
        4'd0:  f = ~a;        4'd1:  f = ~(a | b);  4'd2:  f = ~a & b;     4'd3:  f = '0;
        4'd4:  f = ~(a & b);  4'd5:  f = ~b;        4'd6:  f = a ^ b;      4'd7:  f = a & ~b;
        4'd8:  f = ~a | b;    4'd9:  f = ~(a ^ b);  4'd10: f = b;          4'd11: f = a & b;
        4'd12: f = '1;        4'd13: f = a | ~b;    4'd14: f = a | b;      default: f = a;
      endcase
      return {1'b0, f};
    end
    case (s)
      4'd0:  begin p = a;      q = '0;      end
      4'd1:  begin p = a | b;  q = '0;      end
      4'd2:  begin p = a | ~b; q = '0;      end
      4'd3:  begin p = '0;     q = '1;      end
      4'd4:  begin p = a;      q = a & ~b;  end
      4'd5:  begin p = a | b;  q = a & ~b;  end
      4'd6:  begin p = a;      q = ~b;      end
      4'd7:  begin p = a & ~b; q = '1;      end
      4'd8:  begin p = a;      q = a & b;   end
      4'd9:  begin p = a;      q = b;       end
      4'd10: begin p = a | ~b; q = a & b;   end
      4'd11: begin p = a & b;  q = '1;      end
      4'd12: begin p = a;      q = a;       end
      4'd13: begin p = a | b;  q = a;       end
      4'd14: begin p = a | ~b; q = a;       end
      default: begin p = a;    q = '1;      end
    endcase
    return {1'b0, p} + {1'b0, q} + {{W{1'b0}}, cin};
  endfunction

  // The ALU the sequencer drives; its CN input is active-low.
  always_comb {alu_co, alu_f} = alu181(alu_a, alu_b, alu_s, alu_m, ~alu_cn);

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every result pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && res_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_res_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("res_data", int'(res_data), int'(e.val));
        chk("res_co", int'(res_co), int'(e.co));
        chk("res_zero", int'(res_zero), int'(e.val == '0));
        chk("res_cycle", cyc, e.cyc);
      end
    end
  end

  // Drives one instruction from a negedge, waits for acceptance, updates the
  // reference model and returns at the negedge after the handshake edge.
  task automatic issue(input bit ld, input logic [W-1:0] imm, input logic [3:0] op,
                       input bit m, input logic [1:0] cmode, input logic [1:0] ra,
                       input logic [1:0] rb, input logic [1:0] rd, input bit track,
                       output int hs);
    logic [W:0]   r;
    logic         cin;
    exp_t         e;
    int           n;
    ins_valid = 1'b1; ins_ld = ld; ins_imm = imm; ins_op = op; ins_m = m;
    ins_cmode = cmode; ins_ra = ra; ins_rb = rb; ins_rd = rd;
    n = 0;
    while (!ins_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ins_ready) chk("ready_timeout", 0, 1);
    hs = cyc + 1;
    if (track) begin
      if (ld) begin
        e.val = imm; e.co = m_cflag; e.cyc = hs;
      end else begin
        cin = (cmode == 2'd1) || (cmode == 2'd2 && m_cflag);
        r = alu181(m_regs[ra], m_regs[rb], op, m, cin);
        e.val = r[W-1:0];
        e.co  = m ? m_cflag : r[W];
        e.cyc = hs + 1;
      end
      m_regs[rd] = e.val;
      m_cflag    = e.co;
      sb.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    chk("drain_empty", sb.size(), 0);
    ins_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_regs();
    for (int i = 0; i < 4; i++) begin
      rd_sel = 2'(i);
      #1;
      chk("rd_data", int'(rd_data), int'(m_regs[i]));
    end
  endtask

  initial begin
    int hs, prev_hs, gap;
    bit ld;
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    m_cflag = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rd_sel = 2'(i);
      #1;
      chk("reset_rd_data", int'(rd_data), 0);
    end
    chk("reset_ready", int'(ins_ready), 1);
    chk("reset_res_valid", int'(res_valid), 0);
    chk("reset_alu_m", int'(alu_m), 1);
    chk("reset_alu_cn", int'(alu_cn), 1);
    chk("reset_alu_a", int'(alu_a), 0);
    chk("reset_res_data", int'(res_data), 0);
    chk("reset_res_co", int'(res_co), 0);

    // 9 + 8 = 17 -> 1 with carry
    issue(1, 4'd9, 0, 0, 0, 0, 0, 2'd0, 1, hs);
    issue(1, 4'd8, 0, 0, 0, 0, 0, 2'd1, 1, hs);
    issue(0, 0, 4'b1001, 0, 2'd0, 2'd0, 2'd1, 2'd2, 1, hs);
    drain();
    chk("add_res_data", int'(res_data), 1);
    chk("add_res_co", int'(res_co), 1);

    // XOR of equal values: zero result, carry flag untouched
    issue(1, 4'd5, 0, 0, 0, 0, 0, 2'd0, 1, hs);
    issue(1, 4'd5, 0, 0, 0, 0, 0, 2'd1, 1, hs);
    issue(0, 0, 4'b0110, 1, 2'd0, 2'd0, 2'd1, 2'd2, 1, hs);
    drain();
    chk("xor_res_data", int'(res_data), 0);
    chk("xor_res_zero", int'(res_zero), 1);
    chk("xor_res_co", int'(res_co), 1);

    // Chained add: 0 + 0 + cflag(1) = 1, carry clears
    issue(1, 4'd0, 0, 0, 0, 0, 0, 2'd0, 1, hs);
    issue(1, 4'd0, 0, 0, 0, 0, 0, 2'd1, 1, hs);
    issue(0, 0, 4'b1001, 0, 2'd2, 2'd0, 2'd1, 2'd3, 1, hs);
    drain();
    chk("chain_res_data", int'(res_data), 1);
    chk("chain_res_co", int'(res_co), 0);
    check_regs();

    // Back-to-back with valid held high: accept spacing 3 for ALU, 2 for loads
    prev_hs = -1;
    ld = 1'b0;
    for (int i = 0; i < 12; i++) begin
      bit this_ld;
      this_ld = ($urandom_range(0, 2) == 0);
      issue(this_ld, 4'($urandom), 4'($urandom), 1'($urandom), 2'($urandom),
            2'($urandom), 2'($urandom), 2'($urandom), 1, hs);
      if (prev_hs >= 0) begin
        gap = hs - prev_hs;
        chk("accept_spacing", gap, ld ? 2 : 3);
      end
      prev_hs = hs;
      ld = this_ld;
    end
    drain();
    check_regs();

    // Random traffic with idle gaps
    for (int i = 0; i < 150; i++) begin
      issue(($urandom_range(0, 3) == 0), 4'($urandom), 4'($urandom), 1'($urandom),
            2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 1, hs);
      if ($urandom_range(0, 2) == 0) begin
        ins_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      if (i % 25 == 24) begin
        drain();
        check_regs();
      end
    end
    drain();

    // Abort: reset during EXEC of an add to r3
    issue(1, 4'd7, 0, 0, 0, 0, 0, 2'd0, 1, hs);
    issue(0, 0, 4'b1001, 0, 2'd0, 2'd0, 2'd0, 2'd3, 0, hs);
    ins_valid = 1'b0;
    chk("abort_in_exec_ready", int'(ins_ready), 0);
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    m_cflag = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("abort_no_res_valid", int'(res_valid), 0);
    end
    rd_sel = 2'd3;
    #1;
    chk("abort_r3", int'(rd_data), 0);
    chk("abort_res_co", int'(res_co), 0);
    chk("final_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
